// File: rtl/step_pulse_gen.sv
// Step-interface front end: two debounced buttons become single-cycle pulse4/pulse5 strobes.
// Optional macro AUTO_RUN_EN adds a periodic pulse5 request while run_sw=1 and halt=0.
module step_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int RUN_PERIOD      = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_fpga,
  input  logic       btn_im,
  input  logic       halt,
  input  logic       run_sw,
  output logic       pulse4,
  output logic       pulse5,
  output logic [7:0] step_count,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} deb_state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Index 0 is the FPGA-instruction button, index 1 the IM-step button.
  logic [1:0]       sync1_q, sync2_q;
  deb_state_e       state_q [2];
  deb_state_e       state_d [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       req;
  logic             im_req;
  logic             pulse4_q, pulse4_d, pulse5_q, pulse5_d;
  logic             pending_q, pending_d;
  logic [7:0]       step_count_q;
  logic             busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= {btn_im, btn_fpga};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      req[i]     = 1'b0;
      unique case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            state_d[i] = PRESS_CHK;
            cnt_d[i]   = '0;
          end
        end
        PRESS_CHK: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = HELD;
            req[i]     = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        HELD: begin
          if (!sync2_q[i]) begin
            state_d[i] = REL_CHK;
            cnt_d[i]   = '0;
          end
        end
        REL_CHK: begin
          if (sync2_q[i]) begin
            state_d[i] = HELD;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

`ifdef AUTO_RUN_EN
  localparam int RUN_W = $clog2(RUN_PERIOD + 1);

  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             auto_req;

  always_comb begin
    run_cnt_d = run_cnt_q + RUN_W'(1);
    auto_req  = 1'b0;
    if (!run_sw || halt) begin
      run_cnt_d = '0;
    end else if (run_cnt_q == RUN_W'(RUN_PERIOD - 1)) begin
      run_cnt_d = '0;
      auto_req  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run_cnt_q <= '0;
    else        run_cnt_q <= run_cnt_d;
  end

  assign im_req = req[1] | auto_req;
`else
  logic unused_run_sw;
  assign unused_run_sw = run_sw;
  assign im_req        = req[1];
`endif

  // pulse4 wins a same-cycle collision; the IM request waits one cycle in pending.
  always_comb begin
    pulse4_d  = req[0] & ~halt;
    pulse5_d  = (im_req | pending_q) & ~halt & ~pulse4_d;
    pending_d = pending_q;
    if (halt)                  pending_d = 1'b0;
    else if (im_req & pulse4_d) pending_d = 1'b1;
    else if (pulse5_d)         pending_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse4_q     <= 1'b0;
      pulse5_q     <= 1'b0;
      pending_q    <= 1'b0;
      step_count_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      pulse4_q     <= pulse4_d;
      pulse5_q     <= pulse5_d;
      pending_q    <= pending_d;
      step_count_q <= step_count_q + {7'd0, pulse4_d | pulse5_d};
      busy_q       <= (state_d[0] != IDLE) | (state_d[1] != IDLE);
    end
  end

  assign pulse4     = pulse4_q;
  assign pulse5     = pulse5_q;
  assign step_count = step_count_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: segment table, hand-written corner sequences and random stimulus vs a reference model.
module tb_step_pulse_gen;
  localparam int DEB = 4;
  localparam int CW  = 3;
  localparam int RP  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_fpga = 1'b0, btn_im = 1'b0, halt = 1'b0, run_sw = 1'b0;
  logic       pulse4, pulse5, busy;
  logic [7:0] step_count;

  int checks = 0;
  int failures = 0;

  step_pulse_gen #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CW), .RUN_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .btn_fpga(btn_fpga), .btn_im(btn_im), .halt(halt),
    .run_sw(run_sw), .pulse4(pulse4), .pulse5(pulse5), .step_count(step_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples delayed two edges, then a count of consecutive
  // samples disagreeing with the debounced level; DEB+1 of them flip the level.
  bit m_dly [2][2];
  int m_run [2];
  bit m_lvl [2];
  bit m_pend, m_p4, m_p5;
  int m_cnt, m_auto;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_dly[i][0] = 0; m_dly[i][1] = 0; m_run[i] = 0; m_lvl[i] = 0;
    end
    m_pend = 0; m_p4 = 0; m_p5 = 0; m_cnt = 0; m_auto = 0;
  endfunction

  function automatic void model_edge(bit bf, bit bi, bit h, bit rs);
    bit raw [2];
    bit rq [2];
    bit a, ir;
    raw[0] = bf; raw[1] = bi; a = 0;
    for (int i = 0; i < 2; i++) begin
      bit s;
      s = m_dly[i][1];
      rq[i] = 0;
      if (s != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB + 1) begin
          m_lvl[i] = s; m_run[i] = 0; rq[i] = s;
        end
      end else begin
        m_run[i] = 0;
      end
      m_dly[i][1] = m_dly[i][0];
      m_dly[i][0] = raw[i];
    end
`ifdef AUTO_RUN_EN
    if (!rs || h) m_auto = 0;
    else begin
      m_auto++;
      a = ((m_auto % RP) == 0);
    end
`else
    if (rs) m_auto = 0;
`endif
    ir   = rq[1] | a;
    m_p4 = rq[0] & !h;
    m_p5 = (ir | m_pend) & !h & !m_p4;
    if (h) m_pend = 0;
    else if (ir && m_p4) m_pend = 1;
    else if (m_p5) m_pend = 0;
    if (m_p4 || m_p5) m_cnt = (m_cnt + 1) % 256;
  endfunction

  function automatic int m_busy();
    return int'(m_lvl[0] || m_run[0] != 0 || m_lvl[1] || m_run[1] != 0);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    model_edge(btn_fpga, btn_im, halt, run_sw);
    @(posedge clk); #1;
    chk("model_pulse4", int'(pulse4), int'(m_p4));
    chk("model_pulse5", int'(pulse5), int'(m_p5));
    chk("model_step_count", int'(step_count), m_cnt);
    chk("model_busy", int'(busy), m_busy());
  endtask

  task automatic do_reset();
    reset = 1'b0; #1;
    chk("rst_pulse4", int'(pulse4), 0);
    chk("rst_pulse5", int'(pulse5), 0);
    chk("rst_step_count", int'(step_count), 0);
    chk("rst_busy", int'(busy), 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic set_btns(input int bf, input int bi);
    btn_fpga = 1'(bf); btn_im = 1'(bi);
  endtask

  typedef struct {
    int bf; int bi; int h; int n; int e4; int e5; int ecnt; int ebusy;
  } seg_t;

  seg_t tbl [10];
  int n4, n5, e4, e5, eb, ov;
  int hf, hi, hh, hr;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      '{0, 0, 0,  5, 0, 0, 0, 0},
      '{0, 1, 0, 20, 0, 1, 1, 1},
      '{0, 0, 0, 10, 0, 0, 1, 0},
      '{1, 0, 0, 12, 1, 0, 2, 1},
      '{0, 0, 0, 10, 0, 0, 2, 0},
      '{1, 1, 1, 12, 0, 0, 2, 1},
      '{1, 1, 0,  8, 0, 0, 2, 1},
      '{0, 0, 0, 10, 0, 0, 2, 0},
      '{1, 1, 0, 12, 1, 1, 4, 1},
      '{0, 0, 0, 10, 0, 0, 4, 0}
    };

    @(posedge clk); #1;
    do_reset();

    for (int k = 0; k < 10; k++) begin
      set_btns(tbl[k].bf, tbl[k].bi);
      halt = 1'(tbl[k].h);
      n4 = 0; n5 = 0;
      for (int c = 0; c < tbl[k].n; c++) begin
        tick();
        n4 += int'(pulse4); n5 += int'(pulse5);
      end
      chk($sformatf("seg%0d_pulse4", k), n4, tbl[k].e4);
      chk($sformatf("seg%0d_pulse5", k), n5, tbl[k].e5);
      chk($sformatf("seg%0d_count", k), int'(step_count), tbl[k].ecnt);
      chk($sformatf("seg%0d_busy", k), int'(busy), tbl[k].ebusy);
    end
    halt = 1'b0;

    // Clean press: latency, width, busy start.
    do_reset();
    set_btns(0, 1);
    e5 = -1; eb = -1; n5 = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (pulse5 && e5 < 0) e5 = c;
      if (busy && eb < 0) eb = c;
      n5 += int'(pulse5);
    end
    chk("press_latency", e5, 7);
    chk("busy_start", eb, 3);
    chk("press_width", n5, 1);
    chk("press_count", int'(step_count), 1);
    set_btns(0, 0);
    repeat (10) tick();
    chk("release_busy", int'(busy), 0);

    // Bounce then stable press.
    do_reset();
    e4 = -1; n4 = 0;
    for (int c = 1; c <= 16; c++) begin
      set_btns((c > 4) ? 1 : (c % 2), 0);
      tick();
      if (pulse4 && e4 < 0) e4 = c;
      n4 += int'(pulse4);
    end
    chk("bounce_first_pulse", e4, 11);
    chk("bounce_pulses", n4, 1);
    chk("bounce_count", int'(step_count), 1);
    set_btns(0, 0);
    repeat (10) tick();

    // Collision ordering.
    do_reset();
    set_btns(1, 1);
    e4 = -1; e5 = -1; ov = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (pulse4 && e4 < 0) e4 = c;
      if (pulse5 && e5 < 0) e5 = c;
      if (pulse4 && pulse5) ov++;
    end
    chk("collide_p4_cycle", e4, 7);
    chk("collide_p5_cycle", e5, 8);
    chk("collide_overlap", ov, 0);
    chk("collide_count", int'(step_count), 2);
    set_btns(0, 0);
    repeat (10) tick();

    // Halt raised while pulse5 is pending drops it.
    set_btns(1, 1);
    e4 = 0;
    for (int c = 0; c < 12 && e4 == 0; c++) begin
      tick();
      e4 = int'(pulse4);
    end
    chk("pend_p4_seen", e4, 1);
    halt = 1'b1;
    tick();
    chk("pend_halt_p5", int'(pulse5), 0);
    halt = 1'b0;
    tick();
    chk("pend_after_halt_p5", int'(pulse5), 0);
    chk("pend_count", int'(step_count), 3);
    set_btns(0, 0);
    repeat (10) tick();

    // Reset during PRESS_CHK with the button still held.
    set_btns(0, 1);
    repeat (4) tick();
    chk("midpress_busy", int'(busy), 1);
    do_reset();
    e5 = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (pulse5 && e5 < 0) e5 = c;
    end
    chk("midpress_relatency", e5, 7);
    set_btns(0, 0);
    repeat (10) tick();

    // step_count wrap.
    do_reset();
    for (int it = 0; it < 127; it++) begin
      set_btns(1, 1); repeat (8) tick();
      set_btns(0, 0); repeat (8) tick();
    end
    chk("wrap_pre", int'(step_count), 254);
    set_btns(1, 1);
    repeat (7) tick();
    chk("wrap_255", int'(step_count), 255);
    tick();
    chk("wrap_0", int'(step_count), 0);
    set_btns(0, 0);
    repeat (8) tick();

`ifdef AUTO_RUN_EN
    do_reset();
    run_sw = 1'b1;
    n5 = 0;
    repeat (35) begin tick(); n5 += int'(pulse5); end
    chk("auto_pulses", n5, 3);
    halt = 1'b1;
    n5 = 0;
    repeat (15) begin tick(); n5 += int'(pulse5); end
    chk("auto_halted", n5, 0);
    halt = 1'b0; run_sw = 1'b0;
    tick();
    do_reset();
    run_sw = 1'b1;
    repeat (3) tick();
    set_btns(1, 0);
    e4 = -1; e5 = -1;
    for (int c = 4; c <= 12; c++) begin
      tick();
      if (pulse4 && e4 < 0) e4 = c;
      if (pulse5 && e5 < 0) e5 = c;
    end
    chk("auto_collide_p4", e4, 10);
    chk("auto_collide_p5", e5, 11);
    set_btns(0, 0); run_sw = 1'b0;
    repeat (10) tick();
`endif

    // Random stimulus against the model.
    do_reset();
    hf = 0; hi = 0; hh = 0; hr = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hf == 0) begin btn_fpga = 1'($urandom_range(0, 1)); hf = $urandom_range(1, 12); end
      if (hi == 0) begin btn_im = 1'($urandom_range(0, 1)); hi = $urandom_range(1, 12); end
      if (hh == 0) begin halt = ($urandom_range(0, 9) == 0); hh = $urandom_range(1, 20); end
      if (hr == 0) begin run_sw = 1'($urandom_range(0, 1)); hr = $urandom_range(5, 40); end
      hf--; hi--; hh--; hr--;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
